collision_ctrl: RTL
===================

COLLISION_CTRL -- requirements
Module: collision_ctrl

Interface
REQ-001 Parameter N_OBJ, default 4: number of hostile objects checked (enemies plus enemy projectiles).
REQ-002 Parameter W, default 12: coordinate width in bits, unsigned.
REQ-003 Parameter HALF_X, default 70: horizontal hit half-width; hit when |dx| <= HALF_X.
REQ-004 Parameter HALF_Y, default 90: vertical hit half-height; hit when |dy| < HALF_Y.
REQ-005 Parameter LIVES, default 3: lives loaded at reset and restart; range 1..15.
REQ-006 Parameter INVULN_CYC, default 1000: post-hit invulnerability length in clk cycles; minimum 1.
REQ-007 clk  in  1  system clock; all logic is on the rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 frame_tick  in  1  single-cycle strobe; collision evaluation is enabled only in cycles where it is high.
REQ-010 obj_x  in  N_OBJ*W  packed object X positions; object i occupies bits [i*W +: W].
REQ-011 obj_y  in  N_OBJ*W  packed object Y positions, same packing.
REQ-012 obj_valid  in  N_OBJ  per-object active flag; inactive objects never hit.
REQ-013 plane_x, plane_y  in  W each  player plane position.
REQ-014 restart  in  1  active-high level; restarts the game.
REQ-015 hit_pulse  out  1  one-cycle pulse per life lost.
REQ-016 hit_idx  out  clog2(N_OBJ) (min 1)  index of the object that caused the last hit.
REQ-017 lives  out  4  remaining lives.
REQ-018 invuln  out  1  high while in state INVULN.
REQ-019 crash  out  1  high while in state OVER (game over).

Function
REQ-020 Compute dx and dy as (W+1)-bit signed differences, then take magnitudes; no wrap-around. Example: plane_x=10, obj_x=4000 gives |dx|=3990, which is a miss.
REQ-021 Raw hit for object i = obj_valid[i] AND |dx| <= HALF_X AND |dy| < HALF_Y; the check is symmetric in both axes.
REQ-022 When multiple objects hit in the same cycle, the lowest index wins (selected for hit_idx); only one life is lost.
REQ-023 FSM states are PLAY, INVULN and OVER; the reset state is PLAY.
REQ-024 PLAY, when frame_tick is high and any raw hit is present:
- lives decrements by 1;
- hit_idx is updated;
- hit_pulse is high for exactly the next cycle.
REQ-025 PLAY hit with lives==1: lives goes to 0 and the FSM goes to OVER, with crash=1 in the same cycle as hit_pulse.
REQ-026 PLAY hit with lives>1: the FSM goes to INVULN and the counter loads INVULN_CYC-1.
REQ-027 INVULN: the counter decrements every cycle regardless of frame_tick; hits are ignored; at counter==0 the FSM returns to PLAY the next cycle. INVULN therefore lasts exactly INVULN_CYC cycles.
REQ-028 OVER: hits are ignored; all outputs hold until restart or rst.
REQ-029 restart high in any state causes, next cycle:
- state PLAY;
- lives=LIVES;
- crash=0, invuln=0, hit_pulse=0;
- counter cleared.
REQ-030 If restart and a hit occur in the same cycle, restart wins and no life is lost.
REQ-031 All outputs are registered; latency from a frame_tick cycle to hit_pulse/lives/crash is 1 cycle.
REQ-032 Position inputs are sampled only in frame_tick cycles; no assumption is made on their stability elsewhere.

Reset
REQ-033 rst has priority over restart, frame_tick and all hits.
REQ-034 After rst, next cycle: state PLAY, lives=LIVES, hit_pulse=0, hit_idx=0, invuln=0, crash=0, counter=0.
REQ-035 rst asserted mid-INVULN or in OVER aborts that state with the values of REQ-034.

Verification
REQ-036 Edge hit: plane (500,300), obj0 (570,389) valid, frame_tick -> hit_pulse next cycle, lives 3->2, hit_idx=0, invuln=1. Obj0 at (571,300) or (500,390) -> no hit.
REQ-037 Multi-hit: obj1 and obj3 overlap the plane in the same tick -> hit_idx=1, lives decrements by 1 only.
REQ-038 Invulnerability: hit, then continuous overlap with a tick every cycle, INVULN_CYC=8 -> invuln high exactly 8 cycles; second hit_pulse on the first PLAY tick after; lives 3->2->1.
REQ-039 Game over: three hits from LIVES=3 -> crash=1 and lives=0 with the third hit_pulse; further overlaps leave outputs unchanged; restart -> lives=3, crash=0.
REQ-040 Priority and invalid: restart coincident with a hit -> lives unchanged, no pulse. obj_valid=0 with full overlap -> no hit. Wrap case plane_x=10, obj_x=4090 -> no hit.
REQ-041 Reset: rst asserted during INVULN with counter at 5 -> next cycle state PLAY, lives=3, invuln=0, crash=0.

Source files
------------

// File: rtl/collision_ctrl.sv
// Player-versus-hostile collision detector with a lives/invulnerability/game-over FSM.
// Overlap is checked against all objects in parallel, but only in frame_tick cycles.
module collision_ctrl #(
  parameter int N_OBJ      = 4,
  parameter int W          = 12,
  parameter int HALF_X     = 70,
  parameter int HALF_Y     = 90,
  parameter int LIVES      = 3,
  parameter int INVULN_CYC = 1000,
  localparam int IDX_W     = (N_OBJ > 1) ? $clog2(N_OBJ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_tick,
  input  logic [N_OBJ*W-1:0]   obj_x,
  input  logic [N_OBJ*W-1:0]   obj_y,
  input  logic [N_OBJ-1:0]     obj_valid,
  input  logic [W-1:0]         plane_x,
  input  logic [W-1:0]         plane_y,
  input  logic                 restart,
  output logic                 hit_pulse,
  output logic [IDX_W-1:0]     hit_idx,
  output logic [3:0]           lives,
  output logic                 invuln,
  output logic                 crash
);

  localparam int          CNT_W    = (INVULN_CYC > 1) ? $clog2(INVULN_CYC) : 1;
  localparam logic [W:0]  LIM_X    = (W+1)'(HALF_X);
  localparam logic [W:0]  LIM_Y    = (W+1)'(HALF_Y);
  localparam logic [3:0]  LIVES_LD = 4'(LIVES);

  typedef enum logic [1:0] {PLAY, INVULN, OVER} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [N_OBJ-1:0]   raw_hit;
  logic [IDX_W-1:0]   sel;
  logic               any_hit;

  // One extra bit keeps the difference exact, so coordinates never wrap around.
  function automatic logic [W:0] abs_diff(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [W:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return d[W] ? -d : d;
  endfunction

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    raw_hit = '0;
    for (int i = 0; i < N_OBJ; i++) begin
      raw_hit[i] = obj_valid[i]
                 && (abs_diff(plane_x, obj_x[i*W +: W]) <= LIM_X)
                 && (abs_diff(plane_y, obj_y[i*W +: W]) <  LIM_Y);
    end
  end

  // Scan downwards so the lowest hitting index is the one left standing.
  always_comb begin
    sel = '0;
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      if (raw_hit[i]) sel = IDX_W'(i);
    end
  end

  assign any_hit = |raw_hit;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= PLAY;
      lives     <= LIVES_LD;
      hit_pulse <= 1'b0;
      hit_idx   <= '0;
      invuln    <= 1'b0;
      crash     <= 1'b0;
      cnt       <= '0;
    end else if (restart) begin
      state     <= PLAY;
      lives     <= LIVES_LD;
      hit_pulse <= 1'b0;
      invuln    <= 1'b0;
      crash     <= 1'b0;
      cnt       <= '0;
    end else begin
      hit_pulse <= 1'b0;
      case (state)
        PLAY: begin
          if (frame_tick && any_hit) begin
            lives     <= lives - 4'd1;
            hit_idx   <= sel;
            hit_pulse <= 1'b1;
            if (lives == 4'd1) begin
              state <= OVER;
              crash <= 1'b1;
            end else begin
              state  <= INVULN;
              invuln <= 1'b1;
              cnt    <= CNT_W'(INVULN_CYC - 1);
            end
          end
        end
        INVULN: begin
          if (cnt == '0) begin
            state  <= PLAY;
            invuln <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        OVER:    ;
        default: state <= PLAY;
      endcase
    end
  end

endmodule
